// File: rtl/ipif_arb_pkg.sv
// ipif_arb_pkg: shared types and helpers for the parameter-register arbiter.
//    arb_state_t : access sequencer states (IDLE -> ACCESS -> ACK)
//    byte_merge  : byte-enable merge of one byte of write data into the old register byte
package ipif_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t;
   function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic strb);
      return strb ? new_b : old_b;
   endfunction
endpackage

// File: rtl/ipif_param_arbiter_if.sv
// ipif_param_arbiter_if: requester-side bundle of the parameter arbiter.
//    req/wr/addr/wdata/wstrb : per-requester access request, held until ack
//    ack                     : one-cycle completion pulse per requester
//    err/rdata               : shared response, valid only with ack
//    master = requesters, slave = arbiter
interface ipif_param_arbiter_if #(
   parameter int N_REQ      = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 1
);
   logic [N_REQ-1:0]              req;
   logic [N_REQ-1:0]              wr;
   logic [N_REQ*ADDR_WIDTH-1:0]   addr;
   logic [N_REQ*DATA_WIDTH-1:0]   wdata;
   logic [N_REQ*DATA_WIDTH/8-1:0] wstrb;
   logic [N_REQ-1:0]              ack;
   logic                          err;
   logic [DATA_WIDTH-1:0]         rdata;
   modport master (output req, wr, addr, wdata, wstrb, input ack, err, rdata);
   modport slave  (input req, wr, addr, wdata, wstrb, output ack, err, rdata);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at/after ptr.
//    req   : request vector
//    ptr   : index searched first
//    grant : one-hot winner, idx : winner index, valid : any request present
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);
   int c;
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      c     = 0;
      for (int i = 0; i < N; i++) begin
         c = int'(ptr) + i;
         c = (c >= N) ? c - N : c;
         if (!valid && req[c]) begin
            valid    = 1'b1;
            idx      = IW'(c);
            grant[c] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ipif_param_arbiter.sv
// ipif_param_arbiter: round-robin serialised single-register access to a shared parameter register file.
//    IP_clk, IP_resetn : clock, asynchronous active-low reset
//    bus               : requester bundle (req/wr/addr/wdata/wstrb in, ack/err/rdata out)
//    params_from_IP    : status view returned by reads
//    params_to_IP      : register file contents
//    WrCE, RdCE        : one-cycle per-register write/read pulses
module ipif_param_arbiter
   import ipif_arb_pkg::*;
#(
   parameter int                          N_REQ      = 2,
   parameter int                          DATA_WIDTH = 32,
   parameter int                          N_REG      = 2,
   parameter int                          ADDR_WIDTH = (N_REG > 1) ? $clog2(N_REG) : 1,
   parameter logic [N_REG-1:0]            RO_MASK    = '0,
   parameter logic [N_REG*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                          IP_clk,
   input  logic                          IP_resetn,
   ipif_param_arbiter_if.slave           bus,
   input  logic [N_REG*DATA_WIDTH-1:0]   params_from_IP,
   output logic [N_REG*DATA_WIDTH-1:0]   params_to_IP,
   output logic [N_REG-1:0]              WrCE,
   output logic [N_REG-1:0]              RdCE
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int NB = DATA_WIDTH / 8;

   arb_state_t                        state_q, state_d;
   logic [IW-1:0]                     rr_q, rr_d, gnt_q, gnt_d;
   logic [N_REQ-1:0]                  gnt_oh_q, gnt_oh_d;
   logic                              wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
   logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
   logic [NB-1:0]                     wstrb_q, wstrb_d;
   logic                              res_err_q, res_err_d;
   logic [DATA_WIDTH-1:0]             res_data_q, res_data_d;
   logic [N_REG-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
   logic [N_REQ-1:0]                  ack_q, ack_d;
   logic                              err_q, err_d;
   logic [DATA_WIDTH-1:0]             rdata_q, rdata_d;
   logic [N_REG-1:0]                  wrce_q, wrce_d, rdce_q, rdce_d;
   logic [N_REQ-1:0]                  arb_grant;
   logic [IW-1:0]                     arb_idx;
   logic                              arb_valid;
   logic [DATA_WIDTH-1:0]             merged;
   logic                              bad;
   int                                ri;

   // The requester being acked this cycle still holds req; masking it keeps it from being served twice.
   rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
      .req   (bus.req & ~ack_q),
      .ptr   (rr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   always_comb begin
      // ri stays in range so out-of-range addresses never index past the register file.
      ri  = (int'(addr_q) < N_REG) ? int'(addr_q) : 0;
      bad = (int'(addr_q) >= N_REG) || (wr_q && RO_MASK[ri]);
      merged = '0;
      for (int b = 0; b < NB; b++)
         merged[b*8 +: 8] = byte_merge(regs_q[ri][b*8 +: 8], wdata_q[b*8 +: 8], wstrb_q[b]);
      state_d    = state_q;
      rr_d       = rr_q;
      gnt_d      = gnt_q;
      gnt_oh_d   = gnt_oh_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      res_err_d  = res_err_q;
      res_data_d = res_data_q;
      regs_d     = regs_q;
      ack_d      = '0;
      err_d      = 1'b0;
      rdata_d    = '0;
      wrce_d     = '0;
      rdce_d     = '0;
      if (state_q == IDLE) begin
         if (arb_valid) begin
            state_d  = ACCESS;
            gnt_d    = arb_idx;
            gnt_oh_d = arb_grant;
            wr_d     = bus.wr[arb_idx];
            addr_d   = bus.addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d  = bus.wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            wstrb_d  = bus.wstrb[arb_idx*NB +: NB];
         end
      end else if (state_q == ACCESS) begin
         state_d    = ACK;
         res_err_d  = bad;
         res_data_d = (bad || wr_q) ? '0 : params_from_IP[ri*DATA_WIDTH +: DATA_WIDTH];
         wrce_d[ri] = !bad && wr_q;
         rdce_d[ri] = !bad && !wr_q;
      end else begin
         // The register file changes together with ack, one cycle after the WrCE pulse.
         state_d = IDLE;
         ack_d   = gnt_oh_q;
         err_d   = res_err_q;
         rdata_d = res_data_q;
         if (wr_q && !res_err_q)
            regs_d[ri] = merged;
         rr_d = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
      end
   end

   always_ff @(posedge IP_clk or negedge IP_resetn) begin
      if (!IP_resetn) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         gnt_q      <= '0;
         gnt_oh_q   <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         res_err_q  <= 1'b0;
         res_data_q <= '0;
         regs_q     <= RESET_VAL;
         ack_q      <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         wrce_q     <= '0;
         rdce_q     <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         gnt_q      <= gnt_d;
         gnt_oh_q   <= gnt_oh_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         res_err_q  <= res_err_d;
         res_data_q <= res_data_d;
         regs_q     <= regs_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         wrce_q     <= wrce_d;
         rdce_q     <= rdce_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.err      = err_q;
   assign bus.rdata    = rdata_q;
   assign params_to_IP = regs_q;
   assign WrCE         = wrce_q;
   assign RdCE         = rdce_q;
endmodule

// File: tb/tb_ipif_param_arbiter.sv
// tb_ipif_param_arbiter: scoreboard bench for ipif_param_arbiter with a byte-level register model.
module tb_ipif_param_arbiter;
   localparam int NR = 3;
   localparam int DW = 32;
   localparam int NG = 2;
   localparam int AW = 2;
   localparam logic [NG-1:0]    RO = 2'b01;
   localparam logic [NG*DW-1:0] RV = 64'hCAFE_F00D_0BAD_BEEF;

   typedef struct { bit w; int a; logic [DW-1:0] d; logic [3:0] s; int icyc; } txn_t;
   typedef struct { int id; int cyc; int lat; logic e; logic [DW-1:0] rd; } ack_t;

   logic IP_clk = 1'b0;
   logic IP_resetn = 1'b0;
   logic [NG*DW-1:0] pfi, pto;
   logic [NG-1:0] wrce, rdce, pw, pr;
   logic [DW-1:0] pfi_xor = 32'h5A5A_0F0F;
   logic [DW-1:0] mreg [NG];
   txn_t pend [NR][$];
   ack_t alog [$];
   int waits [NR];
   int cyc = 0;
   int errors = 0;
   int checks = 0;

   ipif_param_arbiter_if #(.N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ipif_param_arbiter #(
      .N_REQ(NR), .DATA_WIDTH(DW), .N_REG(NG), .ADDR_WIDTH(AW), .RO_MASK(RO), .RESET_VAL(RV)
   ) dut (
      .IP_clk(IP_clk), .IP_resetn(IP_resetn), .bus(bus),
      .params_from_IP(pfi), .params_to_IP(pto), .WrCE(wrce), .RdCE(rdce)
   );

   assign pfi = pto ^ {NG{pfi_xor}};

   always #5 IP_clk = ~IP_clk;
   always @(posedge IP_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard: model applies each transaction in the order the DUT acknowledges it.
   always @(posedge IP_clk) begin
      int id;
      txn_t t;
      logic bad;
      logic [DW-1:0] er;
      logic [NG-1:0] ce;
      #1;
      if (!IP_resetn) begin
         for (int j = 0; j < NR; j++) begin
            pend[j].delete();
            waits[j] = 0;
         end
         mreg[0] = RV[DW-1:0];
         mreg[1] = RV[2*DW-1:DW];
      end else if (bus.ack == '0) begin
         chk("idle_err_rdata", {bus.err, bus.rdata}, 64'h0);
      end else begin
         chk("ack_onehot", 64'($onehot(bus.ack)), 64'h1);
         id = 0;
         for (int j = 0; j < NR; j++) if (bus.ack[j]) id = j;
         chk("ack_has_pending", 64'(pend[id].size() != 0), 64'h1);
         if (pend[id].size() != 0) begin
            t   = pend[id].pop_front();
            bad = (t.a >= NG) ? 1'b1 : (t.w && RO[t.a]);
            er  = (bad || t.w) ? '0 : mreg[t.a] ^ pfi_xor;
            ce  = bad ? '0 : NG'(1) << t.a;
            if (t.w && !bad)
               for (int b = 0; b < 4; b++) if (t.s[b]) mreg[t.a][b*8 +: 8] = t.d[b*8 +: 8];
            chk("ack_err", 64'(bus.err), 64'(bad));
            chk("ack_rdata", 64'(bus.rdata), 64'(er));
            chk("wrce_before_ack", 64'(pw), t.w ? 64'(ce) : 64'h0);
            chk("rdce_before_ack", 64'(pr), t.w ? 64'h0 : 64'(ce));
            chk("params_to_IP", pto, {mreg[1], mreg[0]});
            chk("fairness_wait", 64'(waits[id] <= NR), 64'h1);
            waits[id] = 0;
            for (int j = 0; j < NR; j++) if (j != id && pend[j].size() != 0) waits[j]++;
            alog.push_back('{id, cyc, cyc - t.icyc, bus.err, bus.rdata});
         end
      end
      pw = IP_resetn ? wrce : '0;
      pr = IP_resetn ? rdce : '0;
   end

   // Requesters drop req in the cycle after seeing their ack.
   task automatic tick();
      @(posedge IP_clk);
      #2;
      for (int i = 0; i < NR; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
   endtask

   task automatic issue(input int i, input bit w, input int a, input logic [DW-1:0] d, input logic [3:0] s);
      txn_t t;
      bus.wr[i]              = w;
      bus.addr[i*AW +: AW]   = AW'(a);
      bus.wdata[i*DW +: DW]  = d;
      bus.wstrb[i*4 +: 4]    = s;
      bus.req[i]             = 1'b1;
      t = '{w, a, d, s, cyc};
      pend[i].push_back(t);
   endtask

   task automatic wait_done(input logic [NR-1:0] mask);
      int n = 0;
      while ((bus.req & mask) != '0 && n < 100) begin
         tick();
         n++;
      end
      chk("wait_done", 64'(bus.req & mask), 64'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt [2];
      int start;
      bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
      repeat (3) @(posedge IP_clk);
      @(negedge IP_clk) IP_resetn = 1'b1;
      chk("reset_pto", pto, RV);
      for (int n = 0; n < 20; n++) begin
         tick();
         chk("reset_quiet", 64'({bus.ack, wrce, rdce}), 64'h0);
      end
      chk("reset_pto_after", pto, RV);

      issue(0, 1'b1, 1, 32'hDEAD_BEEF, 4'hF);
      wait_done(3'b001);
      chk("wr_latency", 64'(alog[$].lat), 64'd3);
      chk("wr_ack_id", 64'(alog[$].id), 64'd0);
      chk("wr_reg1", pto[63:32], 64'hDEAD_BEEF);

      cnt = '{0, 0};
      start = alog.size();
      for (int n = 0; n < 200 && !(cnt[0] == 4 && cnt[1] == 4 && bus.req[1:0] == 2'b00); n++) begin
         for (int i = 0; i < 2; i++)
            if (!bus.req[i] && cnt[i] < 4) begin
               issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), $urandom, 4'($urandom));
               cnt[i]++;
            end
         tick();
      end
      chk("rot_count", 64'(alog.size() - start), 64'd8);
      for (int n = start + 1; n < alog.size(); n++) begin
         chk("rot_order", 64'(alog[n].id), 64'(1 - alog[n-1].id));
         chk("rot_gap", 64'(alog[n].cyc - alog[n-1].cyc), 64'd3);
      end

      tick();
      issue(0, 1'b1, 0, 32'h1234_5678, 4'hF);
      wait_done(3'b001);
      chk("ro_err", 64'(alog[$].e), 64'h1);
      chk("ro_reg0", pto[31:0], 64'h0BAD_BEEF);
      issue(1, 1'b1, 3, 32'h1234_5678, 4'hF);
      wait_done(3'b010);
      chk("badaddr_err", 64'(alog[$].e), 64'h1);

      issue(2, 1'b1, 1, 32'h1122_3344, 4'hF);
      wait_done(3'b100);
      issue(0, 1'b1, 1, 32'hAABB_CCDD, 4'h5);
      wait_done(3'b001);
      chk("strb_merge", pto[63:32], 64'h11BB_33DD);
      issue(2, 1'b0, 1, 32'h0, 4'h0);
      wait_done(3'b100);
      chk("read_rdata", 64'(alog[$].rd), 64'(32'h11BB_33DD ^ pfi_xor));

      tick();
      issue(1, 1'b1, 1, 32'h5555_5555, 4'hF);
      tick();
      #1 IP_resetn = 1'b0;
      bus.req = '0;
      #1;
      chk("rst_mid_outputs", 64'({bus.ack, bus.err, wrce, rdce}), 64'h0);
      chk("rst_mid_rdata", 64'(bus.rdata), 64'h0);
      chk("rst_mid_pto", pto, RV);
      repeat (3) begin
         tick();
         chk("rst_no_ack", 64'(bus.ack), 64'h0);
      end
      @(negedge IP_clk) IP_resetn = 1'b1;
      tick();
      issue(1, 1'b0, 1, 32'h0, 4'h0);
      wait_done(3'b010);
      chk("post_rst_read", 64'(alog[$].rd), 64'(32'hCAFE_F00D ^ pfi_xor));

      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NR; i++)
            if (!bus.req[i] && $urandom_range(0, 2) == 0)
               issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom, 4'($urandom));
         tick();
      end
      wait_done('1);
      repeat (4) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
